serial_adder_ctrl: RTL and testbench

Bit-serial add/subtract unit. A single one-bit full-adder slice (sum = a^b^c, carry = majority) is reused across WIDTH clock cycles by a small FSM, with operand shift registers and a carry flip-flop. It trades latency for area and sits beside the parallel adders as the low-gate-count arithmetic option. It uses a start/busy/done handshake, and its results are held until the next accepted start.

---
 rtl/serial_adder_ctrl_if.sv | 34 +++
 rtl/serial_adder_ctrl.sv | 120 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/serial_adder_ctrl_if.sv
// ============================================================================
// Module      : serial_adder_ctrl_if
// Description : Start/busy/done handshake and operand/result bundle for the
//               bit-serial add/subtract unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
// ============================================================================
// Module      : serial_adder_ctrl
// Description : Bit-serial add/subtract; one full-adder slice reused over
//               WIDTH cycles, results held until the next accepted start.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  serial_adder_ctrl_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] c_cnt_msb  = CNT_W'(WIDTH - 2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic             r_msb_cin;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  // The single full-adder slice operating on the current LSBs.
  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_acc_next;

  assign w_s        = r_opa[0] ^ r_opb[0] ^ r_carry;
  assign w_c        = (r_opa[0] & r_opb[0]) | (r_opa[0] & r_carry) | (r_opb[0] & r_carry);
  assign w_acc_next = {w_s, r_acc[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_opa     <= '0;
      r_opb     <= '0;
      r_acc     <= '0;
      r_carry   <= 1'b0;
      r_msb_cin <= 1'b0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            // Subtraction is a + ~b + 1.
            r_opa   <= bus.a;
            r_opb   <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub ? 1'b1 : bus.cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          r_carry <= w_c;
          r_opa   <= {1'b0, r_opa[WIDTH-1:1]};
          r_opb   <= {1'b0, r_opb[WIDTH-1:1]};
          r_acc   <= w_acc_next;
          if (r_cnt == c_cnt_msb) begin
            r_msb_cin <= w_c;
          end
          if (r_cnt == c_cnt_last) begin
            r_sum   <= w_acc_next;
            r_cout  <= w_c;
            r_ovf   <= r_msb_cin ^ w_c;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
// ============================================================================
// Module      : tb_serial_adder_ctrl
// Description : Directed and randomized checks of serial_adder_ctrl against
//               an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the two's-complement operands.
  task automatic model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, output logic [W-1:0] es, output logic ec,
                       output logic eo);
    longint full, sr;
    longint sa, sb;
    longint c;
    c    = s ? 1 : longint'(ci);
    full = s ? (longint'(a) + longint'(W'(~b)) + 1) : (longint'(a) + longint'(b) + c);
    es   = W'(full);
    ec   = full[W];
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    sr   = s ? (sa - sb) : (sa + sb + c);
    eo   = (sr > (2**(W-1) - 1)) || (sr < -(2**(W-1)));
  endtask

  // One full operation with timing checks; optionally re-pulses start mid-flight.
  task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input bit poke);
    logic [W-1:0] es;
    logic         ec, eo;
    model(s, a, b, ci, es, ec, eo);
    @(negedge clk);
    bus.start = 1'b1; bus.sub = s; bus.a = a; bus.b = b; bus.cin = ci;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      bus.start = (poke && i == 2) ? 1'b1 : 1'b0;
      bus.a     = poke ? 8'hF0 : W'($urandom);
      bus.b     = poke ? 8'h0F : W'($urandom);
      bus.sub   = 1'($urandom);
      check("busy_during_shift", 32'(bus.busy), 32'd1);
      check("done_during_shift", 32'(bus.done), 32'd0);
    end
    @(negedge clk);
    bus.start = 1'b0;
    check("done_pulse", 32'(bus.done), 32'd1);
    check("busy_at_done", 32'(bus.busy), 32'd0);
    check("sum", 32'(bus.sum), 32'(es));
    check("cout", 32'(bus.cout), 32'(ec));
    check("ovf", 32'(bus.ovf), 32'(eo));
    @(negedge clk);
    check("done_falls", 32'(bus.done), 32'd0);
    check("sum_hold_idle", 32'(bus.sum), 32'(es));
  endtask

  initial begin
    int done_cnt;
    int first_done, last_done;
    logic [W-1:0] es;
    logic         ec, eo;

    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_cout_ovf", {30'd0, bus.cout, bus.ovf}, 32'd0);
    rst_n = 1'b1;

    run_op(1'b0, 8'h5A, 8'h3C, 1'b0, 1'b0);
    run_op(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0);
    run_op(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0);
    run_op(1'b1, 8'h10, 8'h01, 1'b1, 1'b0);
    run_op(1'b1, 8'h00, 8'h01, 1'b0, 1'b0);
    run_op(1'b1, 8'h80, 8'h01, 1'b0, 1'b0);

    // Start while busy must be ignored; result then holds through idle.
    run_op(1'b0, 8'h01, 8'h01, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_sum", 32'(bus.sum), 32'h02);
      check("hold_done", 32'(bus.done), 32'd0);
    end

    // Asynchronous reset mid-operation.
    @(negedge clk);
    bus.start = 1'b1; bus.sub = 1'b0; bus.a = 8'h33; bus.b = 8'h44; bus.cin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    check("arst_sum", 32'(bus.sum), 32'd0);
    check("arst_cout_ovf", {30'd0, bus.cout, bus.ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check("no_done_after_abort", 32'(done_cnt), 32'd0);
    run_op(1'b0, 8'h33, 8'h44, 1'b0, 1'b0);

    // Start held high: one result every W+2 cycles.
    model(1'b0, 8'h21, 8'h12, 1'b1, es, ec, eo);
    @(negedge clk);
    bus.start = 1'b1; bus.sub = 1'b0; bus.a = 8'h21; bus.b = 8'h12; bus.cin = 1'b1;
    done_cnt = 0; first_done = -1; last_done = -1;
    for (int i = 1; i <= 3 * (W + 2); i++) begin
      @(negedge clk);
      if (bus.done) begin
        done_cnt++;
        if (first_done < 0) first_done = i;
        last_done = i;
      end
    end
    bus.start = 1'b0;
    check("cont_done_count", 32'(done_cnt), 32'd3);
    check("cont_first_done", 32'(first_done), 32'(W + 1));
    check("cont_period", 32'(last_done - first_done), 32'(2 * (W + 2)));
    check("cont_sum", 32'(bus.sum), 32'(es));
    repeat (W + 3) @(negedge clk);

    // Randomized operations against the reference model.
    for (int n = 0; n < 24; n++) begin
      run_op(1'($urandom), W'($urandom), W'($urandom), 1'($urandom), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
